// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing definitions: VGA_Timing marker struct, default 640x480@60 mode
// and total-length helpers used by the timing generator and video controller.
package vga_timing_gen_pkg;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        logic valid;
        logic blank_n;
        logic hsync_n;
        logic vsync_n;
        logic end_of_line;
        logic end_of_frame;
    } VGA_Timing;

    localparam VGA_Timing TIMING_IDLE = '{
        valid:        1'b0,
        blank_n:      1'b0,
        hsync_n:      1'b1,
        vsync_n:      1'b1,
        end_of_line:  1'b0,
        end_of_frame: 1'b0
    };

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: per-pixel markers plus the coordinates of that pixel.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    VGA_Timing        timing_o;
    logic [H_W-1:0]   x_o;
    logic [V_W-1:0]   y_o;

    modport master (output timing_o, output x_o, output y_o);
    modport slave  (input  timing_o, input  x_o, input  y_o);

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrap counter over active+porches+sync with region decodes
// taken from the current (pre-increment) count.
module video_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned W      = 11,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_active
);

    localparam int unsigned  TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam int unsigned  SYNC_LO = ACTIVE + FP;
    localparam int unsigned  SYNC_HI = ACTIVE + FP + SYNC;

    logic [31:0] count_u;

    assign count_u     = 32'(count);
    assign wrap        = (count == LAST);
    assign active      = (count_u < ACTIVE);
    assign sync_active = (count_u >= SYNC_LO) && (count_u < SYNC_HI);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: pixel-strobe divider, horizontal/vertical
// axis counters and a registered marker/coordinate stage.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    vga_timing_gen_if.master vid
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;

    logic [H_W-1:0]   h;
    logic             h_wrap;
    logic             h_act;
    logic             h_sync;
    logic [V_W-1:0]   v;
    logic             v_wrap;
    logic             v_act;
    logic             v_sync;
    logic             v_inc;

    VGA_Timing        timing_q;
    logic [H_W-1:0]   x_q;
    logic [V_W-1:0]   y_q;

    // With CLK_DIV == 1 the divider is pinned at 0 == DIV_LAST, so tick follows en_i.
    assign tick  = en_i && (div == DIV_LAST);
    assign v_inc = tick && h_wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div <= '0;
        end else if (!en_i || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    video_axis_counter #(
        .W      (H_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr         (!en_i),
        .inc         (tick),
        .count       (h),
        .wrap        (h_wrap),
        .active      (h_act),
        .sync_active (h_sync)
    );

    video_axis_counter #(
        .W      (V_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr         (!en_i),
        .inc         (v_inc),
        .count       (v),
        .wrap        (v_wrap),
        .active      (v_act),
        .sync_active (v_sync)
    );

    // Strobed markers are recomputed every clock so they stay one clock wide;
    // syncs and coordinates only move on tick so they stay aligned with x/y.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timing_q <= TIMING_IDLE;
            x_q      <= '0;
            y_q      <= '0;
        end else if (!en_i) begin
            timing_q <= TIMING_IDLE;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            timing_q.valid        <= tick;
            timing_q.blank_n      <= tick && h_act && v_act;
            timing_q.end_of_line  <= tick && h_wrap;
            timing_q.end_of_frame <= tick && h_wrap && v_wrap;
            if (tick) begin
                timing_q.hsync_n <= !h_sync;
                timing_q.vsync_n <= !v_sync;
                x_q              <= h;
                y_q              <= v;
            end
        end
    end

    assign vid.timing_o = timing_q;
    assign vid.x_o      = x_q;
    assign vid.y_o      = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small mode at two dividers, default mode)
// checked every clock against a closed-form raster model indexed by enabled-clock count.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int unsigned S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int unsigned S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int unsigned A_D = 1, B_D = 3, C_D = 1;
    localparam int unsigned S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

    typedef struct packed {
        VGA_Timing       t;
        logic [H_W-1:0]  x;
        logic [V_W-1:0]  y;
    } view_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(
        .CLK_DIV(A_D), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_a (.clk_i(clk), .rst_i(rst), .en_i(en), .vid(if_a));

    vga_timing_gen #(
        .CLK_DIV(B_D), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_b (.clk_i(clk), .rst_i(rst), .en_i(en), .vid(if_b));

    vga_timing_gen #(
        .CLK_DIV(C_D)
    ) dut_c (.clk_i(clk), .rst_i(rst), .en_i(en), .vid(if_c));

    initial begin
        if (h_total(S_HA, S_HF, S_HS, S_HB) > 2048 || v_total(S_VA, S_VF, S_VS, S_VB) > 1024 ||
            h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP) > 2048 ||
            v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP) > 1024) begin
            $display("FAIL elab_totals mode totals exceed counter range");
            $fatal(1);
        end
    end

    // Reference: after enabled clock k the raster has produced pixel k/D on tick
    // phases, otherwise still shows the last ticked pixel.
    function automatic view_t model(input int unsigned k, input bit idle, input int unsigned d,
                                    input int unsigned ha, input int unsigned hf,
                                    input int unsigned hs, input int unsigned hb,
                                    input int unsigned va, input int unsigned vf,
                                    input int unsigned vs, input int unsigned vb);
        view_t       r;
        int unsigned ht, vt, q, pix, hp, vp;
        bit          tick, have;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        r.t = TIMING_IDLE;
        r.x = '0;
        r.y = '0;
        if (idle) return r;
        q    = k / d;
        tick = ((k % d) == d - 1);
        have = tick || (q > 0);
        pix  = tick ? q : q - 1;
        if (have) begin
            hp = pix % ht;
            vp = (pix / ht) % vt;
            r.x = H_W'(hp);
            r.y = V_W'(vp);
            r.t.hsync_n = !(hp >= ha + hf && hp < ha + hf + hs);
            r.t.vsync_n = !(vp >= va + vf && vp < va + vf + vs);
            if (tick) begin
                r.t.valid        = 1'b1;
                r.t.blank_n      = (hp < ha) && (vp < va);
                r.t.end_of_line  = (hp == ht - 1);
                r.t.end_of_frame = (hp == ht - 1) && (vp == vt - 1);
            end
        end
        return r;
    endfunction

    bit          m_idle = 1'b1;
    int unsigned m_k    = 0;
    int unsigned m_edge = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_k    <= 0;
        end else if (!en) begin
            m_idle <= 1'b1;
            m_k    <= 0;
        end else begin
            m_idle <= 1'b0;
            m_edge <= m_k;
            m_k    <= m_k + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        view_t got;
        got.t = if_a.timing_o; got.x = if_a.x_o; got.y = if_a.y_o;
        check("view_a", 32'(got), 32'(model(m_edge, m_idle, A_D, S_HA, S_HF, S_HS, S_HB,
                                            S_VA, S_VF, S_VS, S_VB)));
        got.t = if_b.timing_o; got.x = if_b.x_o; got.y = if_b.y_o;
        check("view_b", 32'(got), 32'(model(m_edge, m_idle, B_D, S_HA, S_HF, S_HS, S_HB,
                                            S_VA, S_VF, S_VS, S_VB)));
        got.t = if_c.timing_o; got.x = if_c.x_o; got.y = if_c.y_o;
        check("view_c", 32'(got), 32'(model(m_edge, m_idle, C_D,
                                            DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                                            DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP)));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_a(input int unsigned x, input int unsigned y, input int unsigned budget);
        bit hit = 1'b0;
        for (int unsigned i = 0; i < budget && !hit; i++) begin
            step();
            hit = if_a.timing_o.valid && (32'(if_a.x_o) == x) && (32'(if_a.y_o) == y);
        end
        check("wait_a_pos", 32'(hit), 32'd1);
    endtask

    initial begin
        int unsigned a_eof, b_eof, b_valid, c_eol, c_hs_low, c_blank;
        int          a_last, b_last;
        int unsigned hold;
        int unsigned r;

        a_eof = 0; b_eof = 0; b_valid = 0; c_eol = 0; c_hs_low = 0; c_blank = 0;
        a_last = -1; b_last = -1;

        // Reset state, then a clean run from the origin.
        step();
        check("rst_vsync_c", 32'(if_c.timing_o.vsync_n), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            step();
            if (i == 0) begin
                check("first_valid_c", 32'(if_c.timing_o.valid), 32'd1);
                check("first_blank_c", 32'(if_c.timing_o.blank_n), 32'd1);
            end
            if (if_a.timing_o.end_of_frame) begin
                if (a_last >= 0) check("period_a", 32'(i - a_last), 32'(S_FRAME * A_D));
                a_last = i;
                a_eof++;
            end
            if (if_b.timing_o.end_of_frame) begin
                if (b_last >= 0) check("period_b", 32'(i - b_last), 32'(S_FRAME * B_D));
                b_last = i;
                b_eof++;
            end
            if (if_b.timing_o.valid) b_valid++;
            if (if_c.timing_o.end_of_line) c_eol++;
            if (if_c.timing_o.valid && !if_c.timing_o.hsync_n) c_hs_low++;
            if (if_c.timing_o.blank_n) c_blank++;
        end
        check("eof_count_a", a_eof, 32'd6);
        check("eof_count_b", b_eof, 32'd2);
        check("valid_count_b", b_valid, 32'd733);
        check("eol_count_c", c_eol, 32'd2);
        check("hsync_low_c", c_hs_low, 32'd192);
        check("blank_count_c", c_blank, 32'd1880);

        // Enable dropped mid-line, then restored.
        wait_a(10, 5, 400);
        en = 1'b0;
        step();
        check("en_off_valid_a", 32'(if_a.timing_o.valid), 32'd0);
        check("en_off_hs_c", 32'(if_c.timing_o.hsync_n), 32'd1);
        check("en_off_x_a", 32'(if_a.x_o), 32'd0);
        step();
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("en_on_valid_b", 32'(if_b.timing_o.valid), (i == 3) ? 32'd1 : 32'd0);
        end
        check("en_on_xy_b", {16'(if_b.x_o), 16'(if_b.y_o)}, 32'd0);

        // Asynchronous reset while A is inside vertical sync.
        wait_a(20, 11, 400);
        check("pre_rst_vsync_a", 32'(if_a.timing_o.vsync_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_vsync_a", 32'(if_a.timing_o.vsync_n), 32'd1);
        check("async_x_a", 32'(if_a.x_o), 32'd0);
        check("async_x_b", 32'(if_b.x_o), 32'd0);
        check("async_x_c", 32'(if_c.x_o), 32'd0);
        step();
        rst = 1'b0;

        // Randomised enable drops and reset pulses.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if (!en) begin
                if (hold > 0) hold--;
                else en = 1'b1;
            end else begin
                r = $urandom_range(0, 999);
                if (r < 6) begin
                    en   = 1'b0;
                    hold = $urandom_range(0, 7);
                end else if (r < 9) begin
                    #($urandom_range(1, 3)) rst = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Free-running raster timing generator that sources the `VGA_Timing` struct consumed by the video controller and downstream output stages.
- Divides the system clock into a pixel strobe and counts horizontal/vertical position over a parameterised mode (default 640x480@60).
- Emits registered blanking, sync, end-of-line and end-of-frame markers, plus pixel coordinates.

## Interface

Parameters:
- `CLK_DIV`, 1 — system clocks per pixel (≥1)
- `H_ACTIVE`, 640 — visible pixels per line
- `H_FP`, 16 — horizontal front porch
- `H_SYNC`, 96 — hsync width
- `H_BP`, 48 — horizontal back porch
- `V_ACTIVE`, 480 — visible lines
- `V_FP`, 10 — vertical front porch
- `V_SYNC`, 2 — vsync width
- `V_BP`, 33 — vertical back porch

Ports:
- `clk_i`  in  1 — single clock
- `rst_i`  in  1 — asynchronous, active-high reset
- `en_i`  in  1 — run enable; low holds the raster at origin
- `timing_o`  out  VGA_Timing — `valid`, `blank_n`, `hsync_n`, `vsync_n`, `end_of_line`, `end_of_frame`
- `x_o`  out  11 — horizontal position of the pixel in `timing_o`
- `y_o`  out  10 — vertical position of the pixel in `timing_o`

## Operation

Totals:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 800).
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 525).

Counters:
- Divider `div` runs 0..CLK_DIV-1; `tick` = (div == CLK_DIV-1). When CLK_DIV == 1, `tick` is constantly 1.
- On `tick`, `h` increments; at H_TOTAL-1 it wraps to 0 and `v` increments.
- `v` wraps from V_TOTAL-1 to 0 on the same tick.

Outputs, registered on every clock from the pre-increment (h,v):
- `valid` = tick.
- `blank_n` = tick && h < H_ACTIVE && v < V_ACTIVE.
- `hsync_n` = 0 iff h ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise 1. Level-held between ticks.
- `vsync_n` = 0 iff v ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); otherwise 1. Level-held between ticks.
- `end_of_line` = tick && h == H_TOTAL-1. Strictly one clock wide, since consumers sample it without qualifying by `valid`.
- `end_of_frame` = tick && h == H_TOTAL-1 && v == V_TOTAL-1. Always coincides with `end_of_line`.
- `x_o`/`y_o` = h/v, updated on tick, held otherwise.

Enable and reset:
- `en_i` low: div, h, v are cleared synchronously. Outputs take their reset values on the following clock.
- `en_i` rising: the first tick occurs CLK_DIV clocks later and carries pixel (0,0).
- `rst_i`, including mid-line or mid-frame: all state clears immediately. Reset values are:
  - `valid`, `blank_n`, `end_of_line`, `end_of_frame` = 0
  - `hsync_n`, `vsync_n` = 1
  - `x_o`, `y_o`, div, h, v = 0
- After release, raster restarts at (0,0).

Width rules:
- Counters are sized for 11-bit h / 10-bit v.
- Parameter sets whose totals exceed 2048/1024 are illegal; the bench flags them with an elaboration assertion.

## Timing

- Latency: 1 clock from tick to `timing_o`.
- A pixel is presented every CLK_DIV clocks exactly. There is no backpressure; the consumer must accept every `valid` cycle.
- Sync polarity is negative (`_n`) for the default mode. Polarity is not parameterised.
- Frame period = H_TOTAL × V_TOTAL × CLK_DIV clocks; default 420000 at CLK_DIV = 1.
- `en_i` changes take effect on the next clock edge. There is no mid-frame resume.

## Structure

- `VGA_Timing` struct stays in the shared timing definition file already used by the video controller.
- Add to a shared package:
  - default-mode localparams (H/V active, porches, sync widths)
  - `H_TOTAL`/`V_TOTAL` derivation helpers
- One natural sub-module: `video_axis_counter`, a parameterised wrap counter. It has an increment input and outputs `count`, `wrap`, `active`, `sync_active`. It is instantiated twice, horizontally (inc = tick) and vertically (inc = tick && h wrap).

## Test plan

- **Reset and origin:** assert reset, release with en_i = 1, CLK_DIV = 1 → `valid` = 1 every clock. First pixel is (0,0) with `blank_n` = 1, `hsync_n` = `vsync_n` = 1.
- **Line timing:** default mode.
  - `blank_n` falls at x = 640.
  - `hsync_n` = 0 for x = 656..751, exactly 96 pixels.
  - `end_of_line` is a single cycle at x = 799.
  - Next pixel is (0, y+1).
- **Frame timing:** run a full frame.
  - `vsync_n` = 0 for lines 490..491.
  - Exactly 480 lines carry `blank_n`.
  - `end_of_frame` fires once, at (799,524), coincident with `end_of_line`.
  - Period is 420000 clocks.
- **Divider:** CLK_DIV = 4.
  - `valid` is high 1 clock in 4.
  - `end_of_line` is 1 clock wide.
  - `x_o` holds between ticks.
  - Frame period is 1680000 clocks.
- **Enable:** drop en_i mid-line at (300,100) → next clock outputs idle (`valid` = 0, syncs = 1). Reassert → after CLK_DIV clocks, pixel (0,0).
- **Async reset mid-frame:** pulse rst_i between clock edges at (700,491) → `vsync_n` = 1 and `x_o` = 0 immediately, without waiting for a clock edge.
